// File: rtl/rgb_gray_stream_pkg.sv
// Shared constants and helpers for the RGB-to-gray stream converter.
package gray_pkg;

    // Default luma weights in 1/256 units (they sum to 256)
    localparam int R_COEF_DEF = 54;
    localparam int G_COEF_DEF = 183;
    localparam int B_COEF_DEF = 19;
    localparam int ROUND_DEF  = 1;

    localparam logic MODE_565 = 1'b0;
    localparam logic MODE_888 = 1'b1;

    // Channel bit positions inside one 24-bit lane
    localparam int R565_HI = 15, R565_LO = 11;
    localparam int G565_HI = 10, G565_LO = 5;
    localparam int B565_HI = 4,  B565_LO = 0;
    localparam int R888_HI = 23, R888_LO = 16;
    localparam int G888_HI = 15, G888_LO = 8;
    localparam int B888_HI = 7,  B888_LO = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } prod_t;

    // Bring a lane to 8 bits per channel; 565 is zero-padded, not replicated
    function automatic rgb8_t expandPix(input logic [23:0] pix, input logic mode);
        rgb8_t c;
        if (mode == MODE_888) begin
            c.r = pix[R888_HI:R888_LO];
            c.g = pix[G888_HI:G888_LO];
            c.b = pix[B888_HI:B888_LO];
        end else begin
            c.r = {pix[R565_HI:R565_LO], 3'b000};
            c.g = {pix[G565_HI:G565_LO], 2'b00};
            c.b = {pix[B565_HI:B565_LO], 3'b000};
        end
        return c;
    endfunction

endpackage

// File: rtl/rgb_gray_lane.sv
// One pixel: expand, weight, sum, round, saturate. Two register stages.
module rgb_gray_lane
    import gray_pkg::*;
#(
    parameter int R_COEF = R_COEF_DEF,
    parameter int G_COEF = G_COEF_DEF,
    parameter int B_COEF = B_COEF_DEF,
    parameter int ROUND  = ROUND_DEF
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        en,
    input  logic [23:0] pix,
    input  logic        mode,
    output logic [7:0]  gray
);

    rgb8_t       chan;
    prod_t       prodQ;
    logic [17:0] sum;
    logic [9:0]  scaled;

    assign chan = expandPix(pix, mode);

    // Stage 1: register the three weighted channels
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            prodQ <= '0;
        end else if (en) begin
            prodQ.r <= 16'(R_COEF) * 16'(chan.r);
            prodQ.g <= 16'(G_COEF) * 16'(chan.g);
            prodQ.b <= 16'(B_COEF) * 16'(chan.b);
        end
    end

    // Full-width sum so nothing is lost before the shift
    assign sum    = 18'(prodQ.r) + 18'(prodQ.g) + 18'(prodQ.b) + ((ROUND != 0) ? 18'd128 : 18'd0);
    assign scaled = 10'(sum >> 8);

    // Stage 2: register the saturated 8-bit gray value
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            gray <= '0;
        end else if (en) begin
            gray <= (scaled > 10'd255) ? 8'hFF : scaled[7:0];
        end
    end

endmodule

// File: rtl/rgb_gray_stream.sv
// Streaming RGB565/888 to 8-bit gray, packed little-endian into 32-bit words.
// A single advance enable drives the whole pipe; s_ready is combinational
// from m_ready through that enable.
module rgb_gray_stream
    import gray_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int R_COEF = R_COEF_DEF,
    parameter int G_COEF = G_COEF_DEF,
    parameter int B_COEF = B_COEF_DEF,
    parameter int ROUND  = ROUND_DEF
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic [24*LANES-1:0]   s_data,
    input  logic                  s_mode,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [31:0]           m_data,
    output logic [3:0]            m_keep,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int STAGES = 2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : gBadLanes
        $fatal(1, "rgb_gray_stream: LANES must be 1, 2 or 4");
    end
    if (R_COEF > 255 || G_COEF > 255 || B_COEF > 255 ||
        R_COEF < 0 || G_COEF < 0 || B_COEF < 0) begin : gBadCoef
        $fatal(1, "rgb_gray_stream: coefficients must fit in 8 bits");
    end

    logic                  en;
    logic                  accept;
    logic [STAGES:1]       vldPipe;
    logic [STAGES:1]       lastPipe;
    logic [LANES-1:0][7:0] grayLane;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;

    for (genvar i = 0; i < LANES; i++) begin : gLane
        rgb_gray_lane #(
            .R_COEF(R_COEF), .G_COEF(G_COEF), .B_COEF(B_COEF), .ROUND(ROUND)
        ) uLane (
            .clock (clock),
            .nReset(nReset),
            .en    (en),
            .pix   (s_data[24*i +: 24]),
            .mode  (s_mode),
            .gray  (grayLane[i])
        );
    end

    // Beat valid/last ride alongside the lane data stages
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            vldPipe  <= '0;
            lastPipe <= '0;
        end else if (en) begin
            vldPipe  <= {vldPipe[STAGES-1:1], accept};
            lastPipe <= {lastPipe[STAGES-1:1], s_last};
        end
    end

    // Packer: acc holds the partial word, cnt the bytes already in it
    logic [1:0]  cnt;
    logic [31:0] acc;
    logic [31:0] ins;
    logic [31:0] merged;
    logic [2:0]  newCnt;
    logic        wordDone;
    logic [3:0]  keepNext;

    // Merge the incoming gray bytes above the ones already held
    always_comb begin
        ins                  = '0;
        ins[8*LANES-1:0]     = grayLane;
        merged               = acc | (ins << {cnt, 3'b000});
        newCnt               = {1'b0, cnt} + 3'(LANES);
        wordDone             = newCnt[2] || lastPipe[STAGES];
        case (newCnt)
            3'd1:    keepNext = 4'b0001;
            3'd2:    keepNext = 4'b0011;
            3'd3:    keepNext = 4'b0111;
            default: keepNext = 4'b1111;
        endcase
    end

    // Output register and partial-word state; a full word or end of line flushes
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            cnt     <= '0;
            acc     <= '0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (en) begin
            m_valid <= 1'b0;
            if (vldPipe[STAGES]) begin
                if (wordDone) begin
                    m_data  <= merged;
                    m_keep  <= keepNext;
                    m_last  <= lastPipe[STAGES];
                    m_valid <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc     <= merged;
                    cnt     <= newCnt[1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_gray_stream.sv
// Bench for rgb_gray_stream: a 1-lane/round and a 2-lane/truncate instance,
// expected words queued by the drivers and popped by per-instance monitors.
module tb_rgb_gray_stream;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    int nCmp = 0;
    int nBad = 0;

    // instance 1: LANES=1, ROUND=1
    logic [23:0] sData1 = '0;
    logic        sMode1 = 1'b0, sValid1 = 1'b0, sLast1 = 1'b0, sReady1;
    logic [31:0] mData1;
    logic [3:0]  mKeep1;
    logic        mLast1, mValid1, mReady1;
    // instance 2: LANES=2, ROUND=0
    logic [47:0] sData2 = '0;
    logic        sMode2 = 1'b0, sValid2 = 1'b0, sLast2 = 1'b0, sReady2;
    logic [31:0] mData2;
    logic [3:0]  mKeep2;
    logic        mLast2, mValid2, mReady2;

    logic randRdy = 1'b0;
    logic rdyForce1 = 1'b1, rdyForce2 = 1'b1;

    word_t      q1[$], q2[$];
    logic [7:0] acc1[$], acc2[$];

    rgb_gray_stream #(.LANES(1), .ROUND(1)) dut1 (
        .clock(clk), .nReset(nReset), .s_data(sData1), .s_mode(sMode1),
        .s_valid(sValid1), .s_last(sLast1), .s_ready(sReady1),
        .m_data(mData1), .m_keep(mKeep1), .m_last(mLast1), .m_valid(mValid1),
        .m_ready(mReady1));

    rgb_gray_stream #(.LANES(2), .ROUND(0)) dut2 (
        .clock(clk), .nReset(nReset), .s_data(sData2), .s_mode(sMode2),
        .s_valid(sValid2), .s_last(sLast2), .s_ready(sReady2),
        .m_data(mData2), .m_keep(mKeep2), .m_last(mLast2), .m_valid(mValid2),
        .m_ready(mReady2));

    // m_ready driver: forced level, or random backpressure
    always @(posedge clk) begin
        #1;
        mReady1 = randRdy ? ($urandom_range(0, 3) != 0) : rdyForce1;
        mReady2 = randRdy ? ($urandom_range(0, 2) != 0) : rdyForce2;
    end
    initial begin mReady1 = 1'b1; mReady2 = 1'b1; end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic failNow(input string nm);
        nCmp++;
        nBad++;
        $display("FAIL %s: timed out / unexpected", nm);
    endtask

    function automatic logic [7:0] refGray(input logic [23:0] p, input logic mode, input int rnd);
        int r, g, b, s;
        if (mode) begin
            r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
        end else begin
            r = int'(p[15:11]) * 8; g = int'(p[10:5]) * 4; b = int'(p[4:0]) * 8;
        end
        s = (54 * r + 183 * g + 19 * b + (rnd != 0 ? 128 : 0)) / 256;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    // Monitors: a transfer happens at the next posedge when valid && ready here
    always @(negedge clk) begin
        word_t w;
        if (nReset && mValid1 && mReady1) begin
            if (q1.size() == 0) failNow("d1 unexpected word");
            else begin
                w = q1.pop_front();
                chk("d1 data", mData1, w.data);
                chk("d1 keep", 32'(mKeep1), 32'(w.keep));
                chk("d1 last", 32'(mLast1), 32'(w.last));
            end
        end
        if (nReset && mValid2 && mReady2) begin
            if (q2.size() == 0) failNow("d2 unexpected word");
            else begin
                w = q2.pop_front();
                chk("d2 data", mData2, w.data);
                chk("d2 keep", 32'(mKeep2), 32'(w.keep));
                chk("d2 last", 32'(mLast2), 32'(w.last));
            end
        end
    end

    task automatic flush1(input logic last);
        word_t w;
        w.data = '0; w.keep = '0; w.last = last;
        for (int k = 0; k < acc1.size(); k++) begin
            w.data[8*k +: 8] = acc1[k];
            w.keep[k] = 1'b1;
        end
        q1.push_back(w);
        acc1.delete();
    endtask

    task automatic flush2(input logic last);
        word_t w;
        w.data = '0; w.keep = '0; w.last = last;
        for (int k = 0; k < acc2.size(); k++) begin
            w.data[8*k +: 8] = acc2[k];
            w.keep[k] = 1'b1;
        end
        q2.push_back(w);
        acc2.delete();
    endtask

    // Drive one beat at posedge+1, hold until accepted, then update the model
    task automatic send1(input logic [23:0] p, input logic mode, input logic last);
        bit ok = 0;
        sData1 = p; sMode1 = mode; sLast1 = last; sValid1 = 1'b1;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk); ok = sReady1;
            @(posedge clk); #1;
        end
        sValid1 = 1'b0;
        if (!ok) failNow("d1 s_ready wait");
        else begin
            acc1.push_back(refGray(p, mode, 1));
            if (acc1.size() == 4 || last) flush1(last);
        end
    endtask

    task automatic send2(input logic [47:0] p, input logic mode, input logic last);
        bit ok = 0;
        sData2 = p; sMode2 = mode; sLast2 = last; sValid2 = 1'b1;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk); ok = sReady2;
            @(posedge clk); #1;
        end
        sValid2 = 1'b0;
        if (!ok) failNow("d2 s_ready wait");
        else begin
            acc2.push_back(refGray(p[23:0], mode, 0));
            acc2.push_back(refGray(p[47:24], mode, 0));
            if (acc2.size() == 4 || last) flush2(last);
        end
    endtask

    task automatic expect1(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d; w.keep = k; w.last = l;
        q1.push_back(w);
    endtask

    task automatic expect2(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d; w.keep = k; w.last = l;
        q2.push_back(w);
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 300) begin
            @(posedge clk); n++;
        end
        if (n >= 300) failNow("drain");
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Hand-computed words go straight into the queues; the model bytes are
    // discarded so only the constants are compared.
    task automatic dirWord1(input logic [23:0] p0, p1, p2, p3, input logic mode,
                            input logic [31:0] d);
        expect1(d, 4'hF, 1'b0);
        send1(p0, mode, 0); send1(p1, mode, 0); send1(p2, mode, 0);
        send1(p3, mode, 0);
        void'(q1.pop_back());
    endtask

    task automatic dirWord2(input logic [47:0] p0, p1, input logic mode, input logic [31:0] d);
        expect2(d, 4'hF, 1'b0);
        send2(p0, mode, 0); send2(p1, mode, 0);
        void'(q2.pop_back());
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst m_valid", 32'(mValid1), 32'd0);
        chk("rst m_keep", 32'(mKeep1), 32'd0);
        chk("rst m_data", mData1, 32'd0);
        chk("rst m_last", 32'(mLast1), 32'd0);
        chk("rst s_ready", 32'(sReady1), 32'd1);
        nReset = 1'b1;
        @(posedge clk); #1;

        // 565 white: round -> 0xFB, truncate -> 0xFA
        dirWord1(24'hFFFF, 24'hFFFF, 24'hFFFF, 24'hFFFF, 1'b0, 32'hFBFBFBFB);
        dirWord2({24'hFFFF, 24'hFFFF}, {24'hFFFF, 24'hFFFF}, 1'b0, 32'hFAFAFAFA);
        // 888 red/white alternating
        dirWord1(24'hFF0000, 24'hFFFFFF, 24'hFF0000, 24'hFFFFFF, 1'b1, 32'hFF36FF36);
        dirWord2({24'hFFFFFF, 24'hFF0000}, {24'hFFFFFF, 24'hFF0000}, 1'b1, 32'hFF35FF35);
        drain();

        // End of line after 3 bytes, then a full word starting at byte 0
        expect1(32'h00000000, 4'b0111, 1'b1);
        send1(24'h0, 1, 0); send1(24'h0, 1, 0); send1(24'h0, 1, 1);
        void'(q1.pop_back());
        dirWord1(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 32'hFFFFFFFF);
        // 2-lane partial: green -> 0xB6, blue -> 0x12 (truncating)
        expect2(32'h000012B6, 4'b0011, 1'b1);
        send2({24'h0000FF, 24'h00FF00}, 1, 1);
        void'(q2.pop_back());
        drain();

        // Backpressure: word sits on m_* for 5 cycles with s_ready low
        rdyForce2 = 1'b0;
        @(posedge clk); #1;
        expect2(32'h35FF35FF, 4'hF, 1'b0);
        send2({24'hFF0000, 24'hFFFFFF}, 1, 0); send2({24'hFF0000, 24'hFFFFFF}, 1, 0);
        void'(q2.pop_back());
        begin
            int n = 0;
            while (!mValid2 && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) failNow("stall m_valid wait");
        end
        repeat (5) begin
            @(negedge clk);
            chk("stall s_ready", 32'(sReady2), 32'd0);
            chk("stall m_data", mData2, 32'h35FF35FF);
            chk("stall m_valid", 32'(mValid2), 32'd1);
        end
        @(posedge clk); #1;
        rdyForce2 = 1'b1;
        expect2(32'h0000FAFA, 4'b0011, 1'b1);
        send2({24'hFFFF, 24'hFFFF}, 0, 1);
        void'(q2.pop_back());
        drain();

        // Reset mid-word: the two beats in flight must never come out
        send1(24'h808080, 1, 0); send1(24'h808080, 1, 0);
        @(posedge clk); #2;
        nReset = 1'b0;
        acc1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst m_valid", 32'(mValid1), 32'd0);
        chk("midrst m_data", mData1, 32'd0);
        chk("midrst s_ready", 32'(sReady1), 32'd1);
        nReset = 1'b1;
        @(posedge clk); #1;
        dirWord1(24'h404040, 24'h404040, 24'h404040, 24'h404040, 1'b1, 32'h40404040);
        drain();

        // Random mixed-mode stream with random gaps and backpressure
        randRdy = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            send1(24'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < 5000; i++) begin
            send2({24'($urandom), 24'($urandom)}, 1'($urandom), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        if (acc1.size() != 0) send1(24'h123456, 1, 1);
        if (acc2.size() != 0) send2(48'h123456789ABC, 1, 1);
        drain();
        randRdy = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/rgb_gray_stream.md
RGB_GRAY_STREAM -- requirements
Module: rgb_gray_stream

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning pixels per input beat; legal values 1, 2, 4.
REQ-002 SHALL have parameters R_COEF, G_COEF, B_COEF, defaults 54, 183, 19, meaning 8-bit unsigned luma weights in 1/256 units.
REQ-003 SHALL have parameter ROUND, default 1, meaning add 128 before the >>8 when set.
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port nReset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port s_data, input, 24*LANES, meaning lane i at bits [24i+23:24i]; lane 0 is the earliest pixel.
REQ-007 SHALL have port s_mode, input, 1, meaning 0 = RGB565 in lane bits [15:0], 1 = RGB888; sampled with each accepted beat.
REQ-008 SHALL have ports s_valid/s_last (input, 1) and s_ready (output, 1); s_last meaning end of line.
REQ-009 SHALL have ports m_data (output, 32), m_keep (output, 4), m_last (output, 1), m_valid (output, 1) and m_ready (input, 1).

Function
REQ-010 SHALL accept a beat when s_valid and s_ready are both high in the same cycle.
REQ-011 SHALL expand RGB565 as R8={R5,3'b000}, G8={G6,2'b00}, B8={B5,3'b000}, with [15:11]=R, [10:5]=G, [4:0]=B.
REQ-012 SHALL take RGB888 channels as [23:16]=R, [15:8]=G, [7:0]=B.
REQ-013 SHALL compute gray = min(255, (R_COEF*R8 + G_COEF*G8 + B_COEF*B8 + (ROUND?128:0)) >> 8), using 18-bit unsigned intermediates with no truncation before the shift.
REQ-014 SHALL pipeline each pixel as: stage 1 registers the three products; stage 2 registers the 8-bit gray.
REQ-015 SHALL stage every pixel through a packer that assembles 32-bit words little-endian (first pixel in byte 0), LANES bytes per beat, with a byte counter of 0..3.
REQ-016 SHALL present a word when its 4th byte is packed; m_keep=4'b1111 and m_last=s_last of the completing beat.
REQ-017 SHALL flush a partial word when a beat carrying s_last is packed: m_keep has the low bits set (e.g. 3 bytes gives 4'b0111), the unused bytes are 0, m_last=1, and the byte counter returns to 0.
REQ-018 SHALL have a 3-cycle latency from acceptance of a word-completing beat to m_valid, with m_ready held high.
REQ-019 SHALL use one global advance enable, en = !m_valid || m_ready; s_ready = en, which is combinational from m_ready (documented path).
REQ-020 SHALL freeze all pipeline stages, the packer and m_* while en=0; m_data, m_keep and m_last SHALL hold stable while m_valid && !m_ready.
REQ-021 SHALL sustain one beat per cycle with m_ready held high; a bubble on s_valid SHALL propagate as a bubble with no duplicated bytes.
REQ-022 SHALL apply s_mode per beat, so mixed-mode streams convert each beat in its own mode.
REQ-023 SHALL never emit a word with m_keep=0.

Reset
REQ-024 SHALL clear, while nReset=0: all stage valid flags, the byte counter, m_valid, m_last, m_keep=0 and m_data=0; s_ready then reads 1.
REQ-025 SHALL discard in-flight pixels and any partial word on a reset asserted mid-line, and SHALL NOT emit them after release.
REQ-026 SHALL deassert reset synchronously to clock at the instantiating level; this block takes nReset directly into its asynchronous flops.

Structure
REQ-027 SHALL place the default coefficients, the MODE_565/MODE_888 constants, the ROUND default and the channel bit-position constants in the shared package gray_pkg.
REQ-028 SHALL instantiate a sub-module rgb_gray_lane (one pixel: expand, multiply, sum, round, saturate; 2 register stages) LANES times; the packer SHALL stay in the top level.
REQ-029 SHALL stop elaboration if LANES is not in {1,2,4} or if any coefficient exceeds 255.

Verification
REQ-030 SHALL cover: LANES=1, ROUND=1, mode 565, beats 0xFFFF x4 -> m_data=0xFBFBFBFB, m_keep=0xF; with ROUND=0 -> 0xFAFAFAFA.
REQ-031 SHALL cover: LANES=2, mode 888, beats {0xFF0000,0xFFFFFF} x2 -> m_data=0xFF36FF36 (ROUND=1); with ROUND=0 -> 0xFF35FF35.
REQ-032 SHALL cover: LANES=1, three 888 beats 0x000000 with s_last on the 3rd -> m_data=0x00000000, m_keep=4'b0111, m_last=1; the next word starts at byte 0.
REQ-033 SHALL cover: m_ready low for 5 cycles with m_valid high -> s_ready low, m_data unchanged, zero bytes lost or duplicated after release.
REQ-034 SHALL cover: nReset pulsed after 2 of 4 beats of a word -> no output from those beats; the following 4 beats produce exactly one word.
REQ-035 SHALL cover: a random 10k-beat stream with random s_valid/m_ready/s_mode against a reference model -> bit-exact and in order.
